// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the two-digit scan driver.
// Segment codes are active-high {g,f,e,d,c,b,a}; output polarity is applied elsewhere.
package seg7_pkg;

    typedef enum logic [1:0] {
        S_UNITS = 2'd0,
        S_GAP_U = 2'd1,
        S_TENS  = 2'd2,
        S_GAP_T = 2'd3
    } scan_state_t;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Controller-to-display bundle: BCD digits and mode controls in, display pins out.
// master = game controller / board side, slave = the scan driver.
interface seg7_scan_driver_if;

    logic [3:0] tens_in;
    logic [3:0] units_in;
    logic       load;
    logic       blank_lz;
    logic       blink_en;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] digit_en;
    logic       frame_tick;

    modport master (
        output tens_in, units_in, load, blank_lz, blink_en,
        input  seg, dp, digit_en, frame_tick
    );

    modport slave (
        input  tens_in, units_in, load, blank_lz, blink_en,
        output seg, dp, digit_en, frame_tick
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder; non-BCD nibbles 10-15 show a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        // NOTE: default assigned first so no path through the case can infer a latch.
        o_seg = SEG_DASH;
        case (i_nibble)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed seven-segment driver: scan with one-cycle anti-ghost gaps,
// leading-zero blanking, frame-based blink and a registered frame tick.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLINK_DIV    = 16,
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave bus
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    scan_state_t   r_state, w_state_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_on;
    logic [3:0]    r_tens_q, r_units_q;
    logic          w_units_act, w_tens_act, w_frame;
    logic [3:0]    w_sel_digit;
    logic [6:0]    w_seg_dec, w_seg_act;
    logic [6:0]    r_seg;
    logic [1:0]    r_digit_en;
    logic          r_frame_tick;

    // NOTE: sequential state uses non-blocking assignments and the async reset is in the sensitivity list.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tens_q  <= 4'd0;
            r_units_q <= 4'd0;
        end else if (bus.load) begin
            r_tens_q  <= bus.tens_in;
            r_units_q <= bus.units_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_UNITS;
            r_presc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = '0;
        w_units_act = 1'b0;
        w_tens_act  = 1'b0;
        w_frame     = 1'b0;
        case (r_state)
            S_UNITS: begin
                w_units_act = r_blink_on;
                if (r_presc == PRESC_LAST) w_state_nxt = S_GAP_U;
                else                       w_presc_nxt = r_presc + PW'(1);
            end
            S_GAP_U: w_state_nxt = S_TENS;
            S_TENS: begin
                w_tens_act = r_blink_on && !(bus.blank_lz && (r_tens_q == 4'd0));
                if (r_presc == PRESC_LAST) w_state_nxt = S_GAP_T;
                else                       w_presc_nxt = r_presc + PW'(1);
            end
            S_GAP_T: begin
                w_frame     = 1'b1;
                w_state_nxt = S_UNITS;
            end
            default: w_state_nxt = S_UNITS;
        endcase
    end

    // Blink phase advances once per completed frame; dropping blink_en restores ON at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (!bus.blink_en) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (w_frame) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    assign w_sel_digit = w_tens_act ? r_tens_q : r_units_q;

    seg7_decode u_decode (
        .i_nibble (w_sel_digit),
        .o_seg    (w_seg_dec)
    );

    assign w_seg_act = (w_units_act || w_tens_act) ? w_seg_dec : SEG_OFF;

    // Polarity is applied only here; everything upstream is active-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg        <= {7{COMMON_ANODE}};
            r_digit_en   <= {2{COMMON_ANODE}};
            r_frame_tick <= 1'b0;
        end else begin
            r_seg        <= w_seg_act ^ {7{COMMON_ANODE}};
            r_digit_en   <= {w_tens_act, w_units_act} ^ {2{COMMON_ANODE}};
            r_frame_tick <= w_frame;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.digit_en   = r_digit_en;
    assign bus.frame_tick = r_frame_tick;
    assign bus.dp         = COMMON_ANODE;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream display stage for the mental-math game. It takes the two BCD digits produced by the game controller's binary-to-BCD conversion and drives a 2-digit multiplexed seven-segment display. Features: time-multiplexed scan with anti-ghost gap, leading-zero blanking, blink mode for the result and answer phases, and a frame tick for the controller.

Parameters:
REFRESH_DIV, 1000, clk cycles each digit is lit per scan slot (>=2)
BLINK_DIV, 16, complete scan frames per blink half-period (>=1)
COMMON_ANODE, 1, 1 = segment and digit outputs active-low; 0 = active-high

Ports:
clk  input  1  system clock
rst  input  1  reset
tens_in  input  4  BCD tens digit from controller
units_in  input  4  BCD units digit from controller
load  input  1  single-cycle strobe; captures tens_in/units_in
blank_lz  input  1  1 = suppress tens digit when it is 0
blink_en  input  1  1 = blink whole display
seg  output  7  segments {g,f,e,d,c,b,a}, polarity per COMMON_ANODE
dp  output  1  decimal point, always inactive level
digit_en  output  2  [1]=tens, [0]=units, polarity per COMMON_ANODE
frame_tick  output  1  one-cycle pulse per completed scan frame

Behaviour:
- Clock and reset: clk is the clock; rst is the reset, asynchronous and active-high.
- Reset values:
  - Latched digits tens_q = units_q = 0.
  - Scan state S_UNITS, prescaler 0, blink counter 0, blink phase ON.
  - seg and digit_en all inactive. dp inactive. frame_tick 0.
  - Reset asserted mid-scan forces these values immediately.
- Capture: load high at edge N sets tens_q/units_q from the inputs at edge N. A load during a gap cycle or a blink-off phase is captured normally. The inputs are ignored while load is low.
- Scan FSM states: S_UNITS -> S_GAP_U -> S_TENS -> S_GAP_T -> S_UNITS.
  - Each digit state lasts exactly REFRESH_DIV cycles. The prescaler counts 0..REFRESH_DIV-1 and moves to the gap state on terminal count.
  - Each gap state lasts exactly 1 cycle with both digits off. The prescaler is cleared on entering a digit state.
  - Frame length = 2*REFRESH_DIV + 2 cycles.
- frame_tick: asserted for the one cycle in which the state is S_GAP_T. It appears on the output 1 cycle later, in line with seg.
- Output latency: seg and digit_en are registered. They reflect the state and latched digits of the previous cycle (1-cycle latency).
- Digit enable:
  - In S_UNITS, units is active unless blinked off.
  - In S_TENS, tens is active unless blinked off, or unless blank_lz=1 and tens_q=0.
  - Never both active at once.
- Decode:
  - BCD 0-9 use the standard patterns.
  - Nibbles 10-15 show a dash (g only).
  - Segments read inactive whenever no digit is enabled.
- Blink:
  - When blink_en=1, the blink counter counts frames. The phase toggles every BLINK_DIV frames; in the OFF phase both digits are inactive while scanning continues.
  - When blink_en=0, the counter is cleared and the phase is forced ON.
  - When blink_en rises, the display starts in the ON phase.
- Polarity: COMMON_ANODE=1 inverts seg, digit_en and dp at the output register only. Internal logic is active-high.

Decomposition:
- Package seg7_pkg:
  - Scan-state enum (S_UNITS, S_GAP_U, S_TENS, S_GAP_T).
  - 7-bit active-high segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF.
- Sub-module seg7_decode: combinational 4-bit nibble to 7-bit segment code using the package constants. Instantiated once on the currently selected digit.

Test Plan:
Bench setup for all scenarios: REFRESH_DIV=4, BLINK_DIV=2, COMMON_ANODE=0.
1. Reset, then release with no load -> digit_en=2'b01 and seg=7'b0111111 ("0") from the first cycle after release; dp=0 throughout.
2. load with tens_in=4, units_in=2 ->
   - units slot: seg=7'b1011011, digit_en=2'b01;
   - tens slot: seg=7'b1100110, digit_en=2'b10.
3. Scan timing check -> units on 4 cycles, 1 cycle 2'b00, tens on 4 cycles, 1 cycle 2'b00; frame_tick high exactly once every 10 cycles.
4. load 0/7 with blank_lz=1 -> tens slot digit_en=2'b00 and seg=0.
   Same value with blank_lz=0 -> tens shows seg=7'b0111111.
5. blink_en=1 holding 4/2 -> digits active 20 cycles, off 20 cycles, repeating. Dropping blink_en during the off phase -> display active from the next digit slot.
6. load with tens_in=4'hC ->
   - tens slot seg=7'b1000000 (dash).
   - rst pulsed mid-S_TENS -> all outputs 0 asynchronously; after release, units shows "0".
